// File: rtl/m68k_bus_sequencer_if.sv
// Request, strobe and 68000 bus signals shared by the bus sequencer and its environment.
// The master modport is the sequencer; the slave modport is the requester/bus side.
interface m68k_bus_sequencer_if;
  // Clock-synchroniser strobes and synchronised bus status
  logic        MCCLK_RISING;
  logic        MCCLK_FALLING;
  logic        DTACK_LATCH;
  logic        BERR;
  // Request side
  logic        REQ;
  logic        REQ_READ;
  logic        REQ_WORD;
  logic [23:0] REQ_ADDR;
  logic [15:0] REQ_WDATA;
  logic        ACCEPT;
  logic        DONE;
  logic        ERR;
  logic [15:0] RDATA;
  logic        BUSY;
  // 68000 bus side
  logic [15:0] BUS_DIN;
  logic        AS_N;
  logic        UDS_N;
  logic        LDS_N;
  logic        RW;
  logic [22:0] BUS_ADDR;
  logic [15:0] BUS_DOUT;
  logic        ADDR_OE;
  logic        DATA_OE;

  modport master (
    input  MCCLK_RISING, MCCLK_FALLING, DTACK_LATCH, BERR,
    input  REQ, REQ_READ, REQ_WORD, REQ_ADDR, REQ_WDATA, BUS_DIN,
    output ACCEPT, DONE, ERR, RDATA, BUSY,
    output AS_N, UDS_N, LDS_N, RW, BUS_ADDR, BUS_DOUT, ADDR_OE, DATA_OE
  );

  modport slave (
    output MCCLK_RISING, MCCLK_FALLING, DTACK_LATCH, BERR,
    output REQ, REQ_READ, REQ_WORD, REQ_ADDR, REQ_WDATA, BUS_DIN,
    input  ACCEPT, DONE, ERR, RDATA, BUSY,
    input  AS_N, UDS_N, LDS_N, RW, BUS_ADDR, BUS_DOUT, ADDR_OE, DATA_OE
  );
endinterface

// File: rtl/m68k_bus_sequencer.sv
// 68000 asynchronous bus-cycle sequencer (S0..S7 plus wait states).
// The state only advances on the single-SYSCLK MCCLK edge strobes; every
// output is a register so it changes on the SYSCLK edge that samples a strobe.
module m68k_bus_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input logic                  SYSCLK,
  input logic                  nRESET,
  m68k_bus_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_FAULT
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_WIDTH-1:0] WAIT_MAX      = '1;

  state_t                   state_reg, state_next;
  logic                     req_read_reg, req_read_next;
  logic                     req_word_reg, req_word_next;
  logic [23:0]              req_addr_reg, req_addr_next;
  logic [15:0]              req_wdata_reg, req_wdata_next;
  logic                     accept_reg, accept_next;
  logic                     done_reg, done_next;
  logic                     err_reg, err_next;
  logic [15:0]              rdata_reg, rdata_next;
  logic                     busy_reg, busy_next;
  logic                     as_n_reg, as_n_next;
  logic                     uds_n_reg, uds_n_next;
  logic                     lds_n_reg, lds_n_next;
  logic                     rw_reg, rw_next;
  logic [22:0]              bus_addr_reg, bus_addr_next;
  logic [15:0]              bus_dout_reg, bus_dout_next;
  logic                     addr_oe_reg, addr_oe_next;
  logic                     data_oe_reg, data_oe_next;
  logic                     dtack_flag_reg, dtack_flag_next;
  logic                     berr_seen_reg, berr_seen_next;
  logic                     abort_reg, abort_next;
  logic [TIMEOUT_WIDTH-1:0] wait_cnt_reg, wait_cnt_next;

  // Simultaneous rising and falling strobes cancel each other out
  logic mc_rise, mc_fall;
  assign mc_rise = bus.MCCLK_RISING & ~bus.MCCLK_FALLING;
  assign mc_fall = bus.MCCLK_FALLING & ~bus.MCCLK_RISING;

  // Data-strobe lane selection from the latched request
  logic uds_sel, lds_sel;
  assign uds_sel = req_word_reg | ~req_addr_reg[0];
  assign lds_sel = req_word_reg |  req_addr_reg[0];

  logic do_accept;
  logic cycle_err;

  // Next-state and next-output decode
  always_comb begin
    state_next      = state_reg;
    req_read_next   = req_read_reg;
    req_word_next   = req_word_reg;
    req_addr_next   = req_addr_reg;
    req_wdata_next  = req_wdata_reg;
    accept_next     = 1'b0;
    done_next       = 1'b0;
    err_next        = err_reg;
    rdata_next      = rdata_reg;
    busy_next       = busy_reg;
    as_n_next       = as_n_reg;
    uds_n_next      = uds_n_reg;
    lds_n_next      = lds_n_reg;
    rw_next         = rw_reg;
    bus_addr_next   = bus_addr_reg;
    bus_dout_next   = bus_dout_reg;
    addr_oe_next    = addr_oe_reg;
    data_oe_next    = data_oe_reg;
    dtack_flag_next = dtack_flag_reg;
    berr_seen_next  = berr_seen_reg;
    abort_next      = abort_reg;
    wait_cnt_next   = wait_cnt_reg;
    do_accept       = 1'b0;
    cycle_err       = berr_seen_reg | abort_reg;

    // DTACK is remembered from S2 onwards so an early acknowledge is not lost
    if ((state_reg == ST_S2 || state_reg == ST_S3 || state_reg == ST_S4) && bus.DTACK_LATCH)
      dtack_flag_next = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (mc_rise && bus.REQ) do_accept = 1'b1;
      end
      ST_FAULT: begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
        err_next   = 1'b1;
        rdata_next = 16'hFFFF;
        busy_next  = 1'b0;
      end
      ST_S0: begin
        if (mc_fall) begin
          state_next    = ST_S1;
          bus_addr_next = req_addr_reg[23:1];
          rw_next       = req_read_reg;
          addr_oe_next  = 1'b1;
        end
      end
      ST_S1: begin
        if (mc_rise) begin
          state_next      = ST_S2;
          as_n_next       = 1'b0;
          dtack_flag_next = 1'b0;
          wait_cnt_next   = '0;
          if (req_read_reg) begin
            uds_n_next = ~uds_sel;
            lds_n_next = ~lds_sel;
          end
        end
      end
      ST_S2: begin
        if (mc_fall) begin
          state_next = ST_S3;
          if (!req_read_reg) begin
            bus_dout_next = req_wdata_reg;
            data_oe_next  = 1'b1;
          end
        end
      end
      ST_S3: begin
        if (mc_rise) begin
          state_next = ST_S4;
          if (!req_read_reg) begin
            uds_n_next = ~uds_sel;
            lds_n_next = ~lds_sel;
          end
        end
      end
      ST_S4: begin
        if (mc_fall) begin
          if (bus.BERR) begin
            state_next     = ST_S5;
            berr_seen_next = 1'b1;
          end else if (dtack_flag_reg || bus.DTACK_LATCH) begin
            state_next = ST_S5;
          end else if (TIMEOUT_CYCLES != 0 && wait_cnt_reg == TIMEOUT_LIMIT) begin
            state_next = ST_S5;
            abort_next = 1'b1;
          end else if (wait_cnt_reg != WAIT_MAX) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
          end
        end
      end
      ST_S5: begin
        if (mc_rise) state_next = ST_S6;
      end
      ST_S6: begin
        if (mc_fall) begin
          state_next   = ST_S7;
          as_n_next    = 1'b1;
          uds_n_next   = 1'b1;
          lds_n_next   = 1'b1;
          data_oe_next = 1'b0;
          done_next    = 1'b1;
          busy_next    = 1'b0;
          err_next     = cycle_err;
          if (cycle_err)         rdata_next = 16'hFFFF;
          else if (req_read_reg) rdata_next = bus.BUS_DIN;
        end
      end
      ST_S7: begin
        if (mc_rise) begin
          if (bus.REQ) begin
            do_accept = 1'b1;
          end else begin
            state_next   = ST_IDLE;
            addr_oe_next = 1'b0;
            rw_next      = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Shared by IDLE and the back-to-back path out of S7
    if (do_accept) begin
      req_read_next  = bus.REQ_READ;
      req_word_next  = bus.REQ_WORD;
      req_addr_next  = bus.REQ_ADDR;
      req_wdata_next = bus.REQ_WDATA;
      accept_next    = 1'b1;
      busy_next      = 1'b1;
      berr_seen_next = 1'b0;
      abort_next     = 1'b0;
      state_next     = (bus.REQ_WORD && bus.REQ_ADDR[0]) ? ST_FAULT : ST_S0;
    end
  end

  // State and output registers
  always_ff @(posedge SYSCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_reg      <= ST_IDLE;
      req_read_reg   <= 1'b0;
      req_word_reg   <= 1'b0;
      req_addr_reg   <= '0;
      req_wdata_reg  <= '0;
      accept_reg     <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      rdata_reg      <= '0;
      busy_reg       <= 1'b0;
      as_n_reg       <= 1'b1;
      uds_n_reg      <= 1'b1;
      lds_n_reg      <= 1'b1;
      rw_reg         <= 1'b1;
      bus_addr_reg   <= '0;
      bus_dout_reg   <= '0;
      addr_oe_reg    <= 1'b0;
      data_oe_reg    <= 1'b0;
      dtack_flag_reg <= 1'b0;
      berr_seen_reg  <= 1'b0;
      abort_reg      <= 1'b0;
      wait_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      req_read_reg   <= req_read_next;
      req_word_reg   <= req_word_next;
      req_addr_reg   <= req_addr_next;
      req_wdata_reg  <= req_wdata_next;
      accept_reg     <= accept_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      rdata_reg      <= rdata_next;
      busy_reg       <= busy_next;
      as_n_reg       <= as_n_next;
      uds_n_reg      <= uds_n_next;
      lds_n_reg      <= lds_n_next;
      rw_reg         <= rw_next;
      bus_addr_reg   <= bus_addr_next;
      bus_dout_reg   <= bus_dout_next;
      addr_oe_reg    <= addr_oe_next;
      data_oe_reg    <= data_oe_next;
      dtack_flag_reg <= dtack_flag_next;
      berr_seen_reg  <= berr_seen_next;
      abort_reg      <= abort_next;
      wait_cnt_reg   <= wait_cnt_next;
    end
  end

  assign bus.ACCEPT   = accept_reg;
  assign bus.DONE     = done_reg;
  assign bus.ERR      = err_reg;
  assign bus.RDATA    = rdata_reg;
  assign bus.BUSY     = busy_reg;
  assign bus.AS_N     = as_n_reg;
  assign bus.UDS_N    = uds_n_reg;
  assign bus.LDS_N    = lds_n_reg;
  assign bus.RW       = rw_reg;
  assign bus.BUS_ADDR = bus_addr_reg;
  assign bus.BUS_DOUT = bus_dout_reg;
  assign bus.ADDR_OE  = addr_oe_reg;
  assign bus.DATA_OE  = data_oe_reg;

endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// Directed bench for m68k_bus_sequencer. MCCLK is modelled as 8 SYSCLKs:
// the rising strobe is sampled on the edge that latches a request (offset 0
// from ACCEPT), falling strobes land on offsets 4, 12, 20, ... and rising
// strobes on 8, 16, 24, ...; checks are made on SYSCLK falling edges.
module tb_m68k_bus_sequencer;
  logic SYSCLK = 1'b0;
  logic nRESET = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   off   = 0;

  m68k_bus_sequencer_if bus();

  m68k_bus_sequencer #(.TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(8)) dut (
    .SYSCLK (SYSCLK),
    .nRESET (nRESET),
    .bus    (bus)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Free-running MCCLK edge strobes, one SYSCLK wide
  initial begin
    int ph;
    ph = 7;
    bus.MCCLK_RISING  = 1'b0;
    bus.MCCLK_FALLING = 1'b0;
    forever begin
      @(negedge SYSCLK);
      ph = (ph + 1) % 8;
      bus.MCCLK_RISING  = (ph == 0);
      bus.MCCLK_FALLING = (ph == 4);
    end
  end

  task automatic step_to(input int target);
    while (off < target) begin
      @(negedge SYSCLK);
      off++;
    end
  endtask

  task automatic wait_accept(input string name);
    int n;
    n = 0;
    @(negedge SYSCLK);
    while (bus.ACCEPT !== 1'b1 && n < 20) begin
      @(negedge SYSCLK);
      n++;
    end
    off = 0;
    total++;
    if (bus.ACCEPT !== 1'b1) begin bad++; $display("FAIL %s_accept got=%b exp=1 (timed out)", name, bus.ACCEPT); end
  endtask

  task automatic test_reset;
    nRESET = 1'b0;
    repeat (3) @(negedge SYSCLK);
    total++;
    if ({bus.AS_N, bus.UDS_N, bus.LDS_N, bus.RW, bus.ADDR_OE, bus.DATA_OE, bus.ACCEPT, bus.DONE, bus.ERR, bus.BUSY} !== 10'b1111000000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=1111000000", {bus.AS_N, bus.UDS_N, bus.LDS_N, bus.RW, bus.ADDR_OE, bus.DATA_OE, bus.ACCEPT, bus.DONE, bus.ERR, bus.BUSY});
    end
    total++;
    if ({bus.RDATA, bus.BUS_ADDR, bus.BUS_DOUT} !== 55'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", bus.RDATA, bus.BUS_ADDR, bus.BUS_DOUT);
    end
    nRESET = 1'b1;
    $display("txn reset: released");
  endtask

  task automatic test_word_read;
    bus.REQ_READ = 1'b1; bus.REQ_WORD = 1'b1; bus.REQ_ADDR = 24'h000100; bus.BUS_DIN = 16'hA55A; bus.REQ = 1'b1;
    wait_accept("rd");
    bus.REQ = 1'b0;
    total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL rd_busy got=%b exp=1", bus.BUSY); end
    step_to(3);
    total++; if (bus.ADDR_OE !== 1'b0) begin bad++; $display("FAIL rd_addr_oe_s0 got=%b exp=0", bus.ADDR_OE); end
    step_to(4);
    total++; if ({bus.ADDR_OE, bus.RW} !== 2'b11) begin bad++; $display("FAIL rd_s1_oe_rw got=%b exp=11", {bus.ADDR_OE, bus.RW}); end
    total++; if (bus.BUS_ADDR !== 23'h000080) begin bad++; $display("FAIL rd_bus_addr got=%h exp=000080", bus.BUS_ADDR); end
    step_to(7);
    total++; if (bus.AS_N !== 1'b1) begin bad++; $display("FAIL rd_as_early got=%b exp=1", bus.AS_N); end
    step_to(8);
    total++; if ({bus.AS_N, bus.UDS_N, bus.LDS_N} !== 3'b000) begin bad++; $display("FAIL rd_s2_strobes got=%b exp=000", {bus.AS_N, bus.UDS_N, bus.LDS_N}); end
    step_to(9);  bus.DTACK_LATCH = 1'b1;
    step_to(10); bus.DTACK_LATCH = 1'b0;
    step_to(12);
    total++; if (bus.DATA_OE !== 1'b0) begin bad++; $display("FAIL rd_data_oe got=%b exp=0", bus.DATA_OE); end
    step_to(27);
    total++; if (bus.DONE !== 1'b0) begin bad++; $display("FAIL rd_done_early got=%b exp=0", bus.DONE); end
    step_to(28);
    total++; if ({bus.DONE, bus.ERR, bus.BUSY} !== 3'b100) begin bad++; $display("FAIL rd_done_err_busy got=%b exp=100", {bus.DONE, bus.ERR, bus.BUSY}); end
    total++; if (bus.RDATA !== 16'hA55A) begin bad++; $display("FAIL rd_rdata got=%h exp=a55a", bus.RDATA); end
    total++; if ({bus.AS_N, bus.UDS_N, bus.LDS_N} !== 3'b111) begin bad++; $display("FAIL rd_s7_strobes got=%b exp=111", {bus.AS_N, bus.UDS_N, bus.LDS_N}); end
    step_to(29);
    total++; if (bus.DONE !== 1'b0) begin bad++; $display("FAIL rd_done_width got=%b exp=0", bus.DONE); end
    step_to(33);
    total++; if ({bus.ADDR_OE, bus.RW} !== 2'b01) begin bad++; $display("FAIL rd_idle_oe_rw got=%b exp=01", {bus.ADDR_OE, bus.RW}); end
    $display("txn word read addr=000100 rdata=%h err=%b", bus.RDATA, bus.ERR);
  endtask

  task automatic test_misaligned;
    logic as_seen;
    bus.REQ_READ = 1'b1; bus.REQ_WORD = 1'b1; bus.REQ_ADDR = 24'h000003; bus.REQ = 1'b1;
    wait_accept("mis");
    bus.REQ = 1'b0;
    as_seen = 1'b0;
    step_to(1);
    total++; if ({bus.DONE, bus.ERR, bus.ACCEPT, bus.BUSY} !== 4'b1100) begin bad++; $display("FAIL mis_done_err got=%b exp=1100", {bus.DONE, bus.ERR, bus.ACCEPT, bus.BUSY}); end
    total++; if (bus.RDATA !== 16'hFFFF) begin bad++; $display("FAIL mis_rdata got=%h exp=ffff", bus.RDATA); end
    while (off < 16) begin
      if (bus.AS_N !== 1'b1 || bus.ADDR_OE !== 1'b0) as_seen = 1'b1;
      step_to(off + 1);
    end
    total++; if (as_seen !== 1'b0) begin bad++; $display("FAIL mis_bus_quiet got=%b exp=0", as_seen); end
    $display("txn misaligned word addr=000003 err=%b", bus.ERR);
  endtask

  task automatic test_byte_write;
    bus.REQ_READ = 1'b0; bus.REQ_WORD = 1'b0; bus.REQ_ADDR = 24'h000101; bus.REQ_WDATA = 16'h0033; bus.REQ = 1'b1;
    wait_accept("wr");
    bus.REQ = 1'b0;
    step_to(4);
    total++; if ({bus.ADDR_OE, bus.RW} !== 2'b10) begin bad++; $display("FAIL wr_s1_oe_rw got=%b exp=10", {bus.ADDR_OE, bus.RW}); end
    step_to(8);
    total++; if ({bus.AS_N, bus.UDS_N, bus.LDS_N} !== 3'b011) begin bad++; $display("FAIL wr_s2_strobes got=%b exp=011", {bus.AS_N, bus.UDS_N, bus.LDS_N}); end
    step_to(11);
    total++; if (bus.DATA_OE !== 1'b0) begin bad++; $display("FAIL wr_data_oe_s2 got=%b exp=0", bus.DATA_OE); end
    step_to(12);
    total++; if (bus.DATA_OE !== 1'b1 || bus.BUS_DOUT !== 16'h0033) begin bad++; $display("FAIL wr_s3_dout got=%b/%h exp=1/0033", bus.DATA_OE, bus.BUS_DOUT); end
    step_to(16);
    total++; if ({bus.UDS_N, bus.LDS_N} !== 2'b10) begin bad++; $display("FAIL wr_s4_lanes got=%b exp=10", {bus.UDS_N, bus.LDS_N}); end
    step_to(28);
    total++; if (bus.DONE !== 1'b0) begin bad++; $display("FAIL wr_done_no_wait got=%b exp=0", bus.DONE); end
    step_to(43); bus.DTACK_LATCH = 1'b1;
    step_to(44); bus.DTACK_LATCH = 1'b0;
    step_to(51);
    total++; if ({bus.DONE, bus.DATA_OE} !== 2'b01) begin bad++; $display("FAIL wr_pre_done got=%b exp=01", {bus.DONE, bus.DATA_OE}); end
    step_to(52);
    total++; if ({bus.DONE, bus.ERR, bus.DATA_OE, bus.LDS_N} !== 4'b1001) begin bad++; $display("FAIL wr_done got=%b exp=1001", {bus.DONE, bus.ERR, bus.DATA_OE, bus.LDS_N}); end
    step_to(60);
    $display("txn byte write addr=000101 wdata=0033 err=%b", bus.ERR);
  endtask

  task automatic test_timeout;
    bus.REQ_READ = 1'b1; bus.REQ_WORD = 1'b1; bus.REQ_ADDR = 24'h000200; bus.BUS_DIN = 16'h1357; bus.REQ = 1'b1;
    wait_accept("to");
    bus.REQ = 1'b0;
    step_to(52);
    total++; if (bus.DONE !== 1'b0) begin bad++; $display("FAIL to_done_3wait got=%b exp=0", bus.DONE); end
    step_to(59);
    total++; if ({bus.DONE, bus.AS_N} !== 2'b00) begin bad++; $display("FAIL to_pre_done got=%b exp=00", {bus.DONE, bus.AS_N}); end
    step_to(60);
    total++; if ({bus.DONE, bus.ERR} !== 2'b11 || bus.RDATA !== 16'hFFFF) begin bad++; $display("FAIL to_done got=%b/%h exp=11/ffff", {bus.DONE, bus.ERR}, bus.RDATA); end
    total++; if ({bus.AS_N, bus.UDS_N, bus.LDS_N} !== 3'b111) begin bad++; $display("FAIL to_strobes got=%b exp=111", {bus.AS_N, bus.UDS_N, bus.LDS_N}); end
    step_to(68);
    $display("txn timeout read addr=000200 err=%b rdata=%h", bus.ERR, bus.RDATA);
  endtask

  task automatic test_back_to_back;
    bus.REQ_READ = 1'b1; bus.REQ_WORD = 1'b1; bus.REQ_ADDR = 24'h000400; bus.BUS_DIN = 16'h5AA5; bus.REQ = 1'b1;
    wait_accept("b2b");
    bus.REQ_READ = 1'b0; bus.REQ_ADDR = 24'h000402; bus.REQ_WDATA = 16'h1234;
    step_to(9);  bus.DTACK_LATCH = 1'b1;
    step_to(10); bus.DTACK_LATCH = 1'b0;
    step_to(28);
    total++; if ({bus.DONE, bus.ERR} !== 2'b10 || bus.RDATA !== 16'h5AA5) begin bad++; $display("FAIL b2b_rd_done got=%b/%h exp=10/5aa5", {bus.DONE, bus.ERR}, bus.RDATA); end
    step_to(31);
    total++; if ({bus.ACCEPT, bus.ADDR_OE} !== 2'b01) begin bad++; $display("FAIL b2b_s7 got=%b exp=01", {bus.ACCEPT, bus.ADDR_OE}); end
    step_to(32);
    total++; if ({bus.ACCEPT, bus.BUSY, bus.ADDR_OE} !== 3'b111) begin bad++; $display("FAIL b2b_accept2 got=%b exp=111", {bus.ACCEPT, bus.BUSY, bus.ADDR_OE}); end
    bus.REQ = 1'b0;
    step_to(36);
    total++; if (bus.RW !== 1'b0 || bus.BUS_ADDR !== 23'h000201) begin bad++; $display("FAIL b2b_wr_s1 got=%b/%h exp=0/000201", bus.RW, bus.BUS_ADDR); end
    step_to(41); bus.DTACK_LATCH = 1'b1;
    step_to(42); bus.DTACK_LATCH = 1'b0;
    step_to(44);
    total++; if (bus.DATA_OE !== 1'b1 || bus.BUS_DOUT !== 16'h1234) begin bad++; $display("FAIL b2b_wr_dout got=%b/%h exp=1/1234", bus.DATA_OE, bus.BUS_DOUT); end
    step_to(48);
    total++; if ({bus.UDS_N, bus.LDS_N} !== 2'b00) begin bad++; $display("FAIL b2b_wr_lanes got=%b exp=00", {bus.UDS_N, bus.LDS_N}); end
    step_to(60);
    total++; if ({bus.DONE, bus.ERR} !== 2'b10) begin bad++; $display("FAIL b2b_wr_done got=%b exp=10", {bus.DONE, bus.ERR}); end
    step_to(68);
    $display("txn back-to-back read 000400 + write 000402 err=%b", bus.ERR);
  endtask

  task automatic test_berr;
    bus.REQ_READ = 1'b1; bus.REQ_WORD = 1'b1; bus.REQ_ADDR = 24'h000300; bus.BUS_DIN = 16'h1111; bus.REQ = 1'b1;
    wait_accept("berr");
    bus.REQ = 1'b0;
    step_to(9);  bus.DTACK_LATCH = 1'b1;
    step_to(10); bus.DTACK_LATCH = 1'b0;
    step_to(17); bus.BERR = 1'b1;
    step_to(27);
    total++; if (bus.DONE !== 1'b0) begin bad++; $display("FAIL berr_done_early got=%b exp=0", bus.DONE); end
    step_to(28);
    bus.BERR = 1'b0;
    total++; if ({bus.DONE, bus.ERR} !== 2'b11 || bus.RDATA !== 16'hFFFF) begin bad++; $display("FAIL berr_done got=%b/%h exp=11/ffff", {bus.DONE, bus.ERR}, bus.RDATA); end
    step_to(36);
    $display("txn berr read addr=000300 err=%b", bus.ERR);
  endtask

  task automatic test_reset_mid_cycle;
    int dones;
    bus.REQ_READ = 1'b1; bus.REQ_WORD = 1'b1; bus.REQ_ADDR = 24'h000500; bus.REQ = 1'b1;
    wait_accept("rst");
    bus.REQ = 1'b0;
    step_to(17);
    nRESET = 1'b0;
    #1;
    total++;
    if ({bus.AS_N, bus.UDS_N, bus.LDS_N, bus.RW, bus.ADDR_OE, bus.DATA_OE, bus.ACCEPT, bus.DONE, bus.ERR, bus.BUSY} !== 10'b1111000000) begin
      bad++; $display("FAIL rst_mid_ctrl got=%b exp=1111000000", {bus.AS_N, bus.UDS_N, bus.LDS_N, bus.RW, bus.ADDR_OE, bus.DATA_OE, bus.ACCEPT, bus.DONE, bus.ERR, bus.BUSY});
    end
    total++; if (bus.RDATA !== 16'h0000 || bus.BUS_ADDR !== 23'h0) begin bad++; $display("FAIL rst_mid_data got=%h/%h exp=0/0", bus.RDATA, bus.BUS_ADDR); end
    repeat (3) @(negedge SYSCLK);
    nRESET = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge SYSCLK);
      if (bus.DONE === 1'b1) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d exp=0", dones); end
    $display("txn reset mid-S4 read addr=000500 done_pulses=%0d", dones);
  endtask

  initial begin
    bus.DTACK_LATCH = 1'b0; bus.BERR = 1'b0; bus.REQ = 1'b0; bus.REQ_READ = 1'b0; bus.REQ_WORD = 1'b0;
    bus.REQ_ADDR = 24'h0; bus.REQ_WDATA = 16'h0; bus.BUS_DIN = 16'h0;
    test_reset();
    test_word_read();
    test_misaligned();
    test_byte_write();
    test_timeout();
    test_back_to_back();
    test_berr();
    test_reset_mid_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
